// File: rtl/cfi_pkg.sv
// Shared types and helpers for the per-channel basic-block integrity verdict logic.
package cfi_pkg;

  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 32;
  localparam int CW_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    FLAGGED = 2'd2
  } cfi_state_e;

  // Increment v, clamping at the all-ones value of a cw-bit counter (cw <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned cw);
    logic [31:0] max_v;
    max_v = (cw >= 32) ? '1 : ((32'd1 << cw) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cfi_verdict_mc_if.sv
// Packet/compare/verdict bundle of cfi_verdict_mc; first_* signals exist only
// when CFI_FIRST_ERR_LOG_EN is defined.
interface cfi_verdict_mc_if
  import cfi_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF,
  parameter int CW  = CW_DEF
);
  logic [NCH-1:0]    pkt_start;
  logic [NCH-1:0]    pkt_end;
  logic [NCH-1:0]    chk_valid;
  logic [NCH*W-1:0]  dupl_bblock;
  logic [NCH*W-1:0]  jump_bblock;
  logic              err_clr;
  logic [NCH-1:0]    pkt_done;
  logic [NCH-1:0]    pkt_drop;
  logic [NCH*CW-1:0] err_cnt;
  logic              irq;
`ifdef CFI_FIRST_ERR_LOG_EN
  logic [NCH*W-1:0]  first_exp;
  logic [NCH*W-1:0]  first_act;
  logic [NCH-1:0]    first_vld;
`endif

  modport master (
    output pkt_start, pkt_end, chk_valid, dupl_bblock, jump_bblock, err_clr,
`ifdef CFI_FIRST_ERR_LOG_EN
    input  first_exp, first_act, first_vld,
`endif
    input  pkt_done, pkt_drop, err_cnt, irq
  );

  modport slave (
    input  pkt_start, pkt_end, chk_valid, dupl_bblock, jump_bblock, err_clr,
`ifdef CFI_FIRST_ERR_LOG_EN
    output first_exp, first_act, first_vld,
`endif
    output pkt_done, pkt_drop, err_cnt, irq
  );

endinterface

// File: rtl/cfi_chan.sv
// One core channel: packet FSM, address compare, saturating mismatch counter and,
// with CFI_FIRST_ERR_LOG_EN, a first-mismatch capture.
module cfi_chan
  import cfi_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          core_sp_clk,
  input  logic          reset,
  input  logic          pkt_start,
  input  logic          pkt_end,
  input  logic          chk_valid,
  input  logic          err_clr,
  input  logic [W-1:0]  dupl_bblock,
  input  logic [W-1:0]  jump_bblock,
  output logic          pkt_done,
  output logic          pkt_drop,
  output logic [CW-1:0] err_cnt,
`ifdef CFI_FIRST_ERR_LOG_EN
  output logic [W-1:0]  first_exp,
  output logic [W-1:0]  first_act,
  output logic          first_vld,
`endif
  output logic          drop_evt
);

  cfi_state_e state_q, state_d;
  logic       in_pkt, mismatch, verdict, drop_val;

  // The pkt_start cycle is the first word of the new packet, so it is compared too.
  assign in_pkt   = (state_q != IDLE);
  assign mismatch = chk_valid && (in_pkt || pkt_start) && (dupl_bblock != jump_bblock);
  assign drop_evt = verdict && drop_val;

  // NOTE: every output of this block is given a default first, so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    verdict  = 1'b0;
    drop_val = 1'b0;
    if (pkt_start && in_pkt) begin
      // Missing end: force a drop on the open packet and start the new one.
      verdict  = 1'b1;
      drop_val = 1'b1;
      state_d  = mismatch ? FLAGGED : ACTIVE;
    end else if (pkt_start && pkt_end) begin
      verdict  = 1'b1;
      drop_val = mismatch;
      state_d  = IDLE;
    end else if (pkt_start) begin
      state_d = mismatch ? FLAGGED : ACTIVE;
    end else if (in_pkt && pkt_end) begin
      verdict  = 1'b1;
      drop_val = (state_q == FLAGGED) || mismatch;
      state_d  = IDLE;
    end else if (mismatch) begin
      state_d = FLAGGED;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge core_sp_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pkt_done <= 1'b0;
      pkt_drop <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      pkt_done <= verdict;
      if (verdict) pkt_drop <= drop_val;
      if (err_clr)       err_cnt <= '0;
      else if (mismatch) err_cnt <= CW'(sat_inc(32'(err_cnt), CW));
    end
  end

`ifdef CFI_FIRST_ERR_LOG_EN
  always_ff @(posedge core_sp_clk) begin
    if (reset) begin
      first_vld <= 1'b0;
    end else if (err_clr) begin
      first_vld <= 1'b0;
    end else if (mismatch && !first_vld) begin
      first_vld <= 1'b1;
    end
  end

  // NOTE: captured addresses are qualified by first_vld, so these data flops carry no reset.
  always_ff @(posedge core_sp_clk) begin
    if (!reset && !err_clr && mismatch && !first_vld) begin
      first_exp <= dupl_bblock;
      first_act <= jump_bblock;
    end
  end
`endif

endmodule

// File: rtl/cfi_verdict_mc.sv
// NCH independent integrity-check channels with a shared drop interrupt.
// Optional first-mismatch log: define CFI_FIRST_ERR_LOG_EN.
module cfi_verdict_mc
  import cfi_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF,
  parameter int CW  = CW_DEF
) (
  input logic             core_sp_clk,
  input logic             reset,
  cfi_verdict_mc_if.slave bus
);

  logic          done_c [NCH];
  logic          drop_c [NCH];
  logic [CW-1:0] cnt_c  [NCH];
  logic          evt_c  [NCH];
`ifdef CFI_FIRST_ERR_LOG_EN
  logic [W-1:0]  fexp_c [NCH];
  logic [W-1:0]  fact_c [NCH];
  logic          fvld_c [NCH];
`endif
  logic          any_drop;
  logic          irq_q;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    cfi_chan #(.W(W), .CW(CW)) u_chan (
      .core_sp_clk (core_sp_clk),
      .reset       (reset),
      .pkt_start   (bus.pkt_start[c]),
      .pkt_end     (bus.pkt_end[c]),
      .chk_valid   (bus.chk_valid[c]),
      .err_clr     (bus.err_clr),
      .dupl_bblock (bus.dupl_bblock[c*W +: W]),
      .jump_bblock (bus.jump_bblock[c*W +: W]),
      .pkt_done    (done_c[c]),
      .pkt_drop    (drop_c[c]),
      .err_cnt     (cnt_c[c]),
`ifdef CFI_FIRST_ERR_LOG_EN
      .first_exp   (fexp_c[c]),
      .first_act   (fact_c[c]),
      .first_vld   (fvld_c[c]),
`endif
      .drop_evt    (evt_c[c])
    );
  end

  always_comb begin
    any_drop     = 1'b0;
    bus.pkt_done = '0;
    bus.pkt_drop = '0;
    bus.err_cnt  = '0;
`ifdef CFI_FIRST_ERR_LOG_EN
    bus.first_exp = '0;
    bus.first_act = '0;
    bus.first_vld = '0;
`endif
    for (int c = 0; c < NCH; c++) begin
      any_drop                 = any_drop | evt_c[c];
      bus.pkt_done[c]          = done_c[c];
      bus.pkt_drop[c]          = drop_c[c];
      bus.err_cnt[c*CW +: CW]  = cnt_c[c];
`ifdef CFI_FIRST_ERR_LOG_EN
      bus.first_exp[c*W +: W]  = fexp_c[c];
      bus.first_act[c*W +: W]  = fact_c[c];
      bus.first_vld[c]         = fvld_c[c];
`endif
    end
  end

  // Registered so irq lines up with the pkt_done pulse of the dropping channel.
  always_ff @(posedge core_sp_clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= any_drop;
  end

  assign bus.irq = irq_q;

endmodule

// File: tb/tb_cfi_verdict_mc.sv
// Self-checking bench for cfi_verdict_mc: directed scenarios plus random traffic
// against a packet-level reference model.
module tb_cfi_verdict_mc;
  import cfi_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic core_sp_clk = 1'b0;
  logic reset;
  always #5 core_sp_clk = ~core_sp_clk;

  cfi_verdict_mc_if #(.NCH(NCH), .W(W), .CW(CW)) bus ();

  cfi_verdict_mc #(.NCH(NCH), .W(W), .CW(CW)) dut (
    .core_sp_clk (core_sp_clk),
    .reset       (reset),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // stimulus for the next cycle
  logic         s_rst, s_clr;
  logic         s_start [NCH];
  logic         s_end   [NCH];
  logic         s_vld   [NCH];
  logic [W-1:0] s_exp   [NCH];
  logic [W-1:0] s_act   [NCH];

  // reference model: packet-level view of each channel
  bit           m_open [NCH];
  bit           m_bad  [NCH];
  int           m_cnt  [NCH];
  bit           m_done [NCH];
  bit           m_drop [NCH];
  bit           m_irq;
  bit           m_fvld [NCH];
  logic [W-1:0] m_fexp [NCH];
  logic [W-1:0] m_fact [NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stim();
    s_rst = 1'b0;
    s_clr = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      s_start[c] = 1'b0; s_end[c] = 1'b0; s_vld[c] = 1'b0;
      s_exp[c] = '0; s_act[c] = '0;
    end
  endtask

  task automatic word(input int c, input logic [W-1:0] ex, input logic [W-1:0] ac);
    s_vld[c] = 1'b1; s_exp[c] = ex; s_act[c] = ac;
  endtask

  task automatic model_step();
    bit mm;
    m_irq = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_done[c] = 1'b0;
      if (s_rst) begin
        m_open[c] = 0; m_bad[c] = 0; m_cnt[c] = 0; m_drop[c] = 0; m_fvld[c] = 0;
        continue;
      end
      mm = s_vld[c] && (m_open[c] || s_start[c]) && (s_exp[c] != s_act[c]);
      if (s_clr) m_cnt[c] = 0;
      else if (mm && m_cnt[c] < CMAX) m_cnt[c]++;
      if (s_clr) m_fvld[c] = 0;
      else if (mm && !m_fvld[c]) begin
        m_fvld[c] = 1; m_fexp[c] = s_exp[c]; m_fact[c] = s_act[c];
      end
      if (s_start[c] && m_open[c]) begin
        m_done[c] = 1; m_drop[c] = 1; m_bad[c] = mm;
      end else if (s_start[c] && s_end[c]) begin
        m_done[c] = 1; m_drop[c] = mm;
      end else if (s_start[c]) begin
        m_open[c] = 1; m_bad[c] = mm;
      end else if (m_open[c] && s_end[c]) begin
        m_done[c] = 1; m_drop[c] = m_bad[c] || mm; m_open[c] = 0;
      end else if (m_open[c]) begin
        m_bad[c] = m_bad[c] || mm;
      end
      if (m_done[c] && m_drop[c]) m_irq = 1'b1;
    end
  endtask

  // Drive on the falling edge, update the model at the rising edge, compare 1 time unit later.
  task automatic cycle();
    @(negedge core_sp_clk);
    reset       = s_rst;
    bus.err_clr = s_clr;
    for (int c = 0; c < NCH; c++) begin
      bus.pkt_start[c]          = s_start[c];
      bus.pkt_end[c]            = s_end[c];
      bus.chk_valid[c]          = s_vld[c];
      bus.dupl_bblock[c*W +: W] = s_exp[c];
      bus.jump_bblock[c*W +: W] = s_act[c];
    end
    @(posedge core_sp_clk);
    model_step();
    #1;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("done%0d", c), 64'(bus.pkt_done[c]), 64'(m_done[c]));
      check($sformatf("drop%0d", c), 64'(bus.pkt_drop[c]), 64'(m_drop[c]));
      check($sformatf("cnt%0d", c), 64'(bus.err_cnt[c*CW +: CW]), 64'(m_cnt[c]));
`ifdef CFI_FIRST_ERR_LOG_EN
      check($sformatf("fvld%0d", c), 64'(bus.first_vld[c]), 64'(m_fvld[c]));
      if (m_fvld[c]) begin
        check($sformatf("fexp%0d", c), 64'(bus.first_exp[c*W +: W]), 64'(m_fexp[c]));
        check($sformatf("fact%0d", c), 64'(bus.first_act[c*W +: W]), 64'(m_fact[c]));
      end
`endif
    end
    check("irq", 64'(bus.irq), 64'(m_irq));
    clear_stim();
  endtask

  initial begin
    clear_stim();
    s_rst = 1'b1; cycle();
    s_rst = 1'b1; cycle();
    check("rst_done", 64'(bus.pkt_done), 64'h0);
    check("rst_cnt", 64'(bus.err_cnt), 64'h0);

    // ch0: clean three-word packet
    s_start[0] = 1; cycle();
    word(0, 32'h100, 32'h100); cycle();
    word(0, 32'h104, 32'h104); cycle();
    word(0, 32'h108, 32'h108); cycle();
    s_end[0] = 1; cycle();
    check("ch0_done", 64'(bus.pkt_done[0]), 64'h1);
    check("ch0_drop", 64'(bus.pkt_drop[0]), 64'h0);
    cycle();
    check("ch0_pulse", 64'(bus.pkt_done[0]), 64'h0);

    // ch1: second word mismatches
    s_start[1] = 1; cycle();
    word(1, 32'h1FC, 32'h1FC); cycle();
    word(1, 32'h200, 32'h2F0); cycle();
    word(1, 32'h204, 32'h204); cycle();
    s_end[1] = 1; cycle();
    check("ch1_drop", 64'(bus.pkt_drop[1]), 64'h1);
    check("ch1_irq", 64'(bus.irq), 64'h1);
    check("ch1_cnt", 64'(bus.err_cnt[1*CW +: CW]), 64'h1);

    // ch2: restart without end, then a clean packet
    s_start[2] = 1; cycle();
    word(2, 32'h300, 32'h300); cycle();
    s_start[2] = 1; cycle();
    check("ch2_forced", 64'(bus.pkt_drop[2]), 64'h1);
    word(2, 32'h304, 32'h304); cycle();
    s_end[2] = 1; cycle();
    check("ch2_clean", 64'(bus.pkt_drop[2]), 64'h0);

    // ch3: saturation, then clear against a simultaneous mismatch
    s_start[3] = 1; cycle();
    for (int i = 0; i < 20; i++) begin word(3, 32'h400 + 32'(i), 32'h0); cycle(); end
    check("ch3_sat", 64'(bus.err_cnt[3*CW +: CW]), 64'(CMAX));
    word(3, 32'h500, 32'h0); s_clr = 1; cycle();
    check("ch3_clr", 64'(bus.err_cnt[3*CW +: CW]), 64'h0);
    s_end[3] = 1; cycle();

    // mismatch on the end cycle, and a one-word failing packet
    s_start[0] = 1; cycle();
    word(0, 32'h600, 32'h601); s_end[0] = 1; cycle();
    check("end_mm", 64'(bus.pkt_drop[0]), 64'h1);
    s_start[1] = 1; s_end[1] = 1; word(1, 32'h700, 32'h777); cycle();
    check("one_word", 64'(bus.pkt_drop[1]), 64'h1);

    // reset mid-packet on all channels, then compares in IDLE
    for (int c = 0; c < NCH; c++) s_start[c] = 1;
    cycle();
    for (int c = 0; c < NCH; c++) begin word(c, 32'h800, 32'h801); s_end[c] = 1; end
    s_rst = 1; cycle();
    check("mid_rst_done", 64'(bus.pkt_done), 64'h0);
    check("mid_rst_irq", 64'(bus.irq), 64'h0);
    for (int c = 0; c < NCH; c++) word(c, 32'h900, 32'h901);
    cycle();
    check("idle_cnt", 64'(bus.err_cnt), 64'h0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      s_rst = ($urandom_range(199, 0) == 0);
      s_clr = ($urandom_range(63, 0) == 0);
      for (int c = 0; c < NCH; c++) begin
        s_start[c] = ($urandom_range(7, 0) == 0);
        s_end[c]   = ($urandom_range(5, 0) == 0);
        if (s_start[c] && s_end[c] && m_open[c]) s_end[c] = 1'b0;
        s_vld[c] = $urandom_range(1, 0) == 1;
        s_exp[c] = $urandom;
        s_act[c] = ($urandom_range(3, 0) == 0) ? s_exp[c] ^ (32'd1 << $urandom_range(31, 0))
                                               : s_exp[c];
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
